fixedpoint_div: RTL and testbench

Sequential signed fixed-point divider, the inverse companion to the `fixedpoint` add/multiply block. It takes two signed Q7.8 operands on a start strobe and computes `a / b` with one restoring-division step per cycle. The result is saturated to the same 17-bit signed Q8.8 result width that `fixedpoint` produces. It sits beside `fixedpoint` in the datapath and uses a start/busy/done handshake toward the controlling logic.

---
 rtl/fixedpoint_div.sv | 177 +++++++++++++++++
 tb/tb_fixedpoint_div.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixedpoint_div.sv
// Sequential signed Q7.8 divider: one restoring step per cycle, result saturated
// to the 17-bit Q8.8 width used by the fixedpoint add/multiply block.
module fixedpoint_div #(
    parameter int W    = 16,
    parameter int FRAC = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W:0]   q_o,
    output logic         dz_o,
    output logic         sat_o
);

    localparam int ITER = W + FRAC;
    localparam int CW   = $clog2(ITER + 1);

    // Largest magnitudes representable in the W+1 bit result for each sign.
    localparam logic [ITER-1:0] POS_LIM = ITER'({W{1'b1}});
    localparam logic [ITER-1:0] NEG_LIM = ITER'({1'b1, {W{1'b0}}});
    localparam logic [W:0]      POS_MAX = {1'b0, {W{1'b1}}};
    localparam logic [W:0]      NEG_MAX = {1'b1, {W{1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    bmag_q, bmag_d;
    logic            sign_q, sign_d;
    logic            bzero_q, bzero_d;
    logic [ITER-1:0] div_q, div_d;
    logic [ITER-1:0] quo_q, quo_d;
    logic [W:0]      rem_q, rem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W:0]      q_q, q_d;
    logic            dz_q, dz_d;
    logic            sat_q, sat_d;
    logic            done_q, done_d;

    logic [W-1:0]    amagIn;
    logic [W-1:0]    bmagIn;
    logic [W:0]      remShift;
    logic [W:0]      mag;
    logic            clamp;

    always_comb begin
        state_d  = state_q;
        bmag_d   = bmag_q;
        sign_d   = sign_q;
        bzero_d  = bzero_q;
        div_d    = div_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        q_d      = q_q;
        dz_d     = dz_q;
        sat_d    = sat_q;
        done_d   = 1'b0;
        mag      = '0;
        clamp    = 1'b0;

        // 0x8000 negates to itself, which read unsigned is exactly 32768.
        amagIn   = a_i[W-1] ? (~a_i + W'(1)) : a_i;
        bmagIn   = b_i[W-1] ? (~b_i + W'(1)) : b_i;
        remShift = {rem_q[W-1:0], div_q[ITER-1]};

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = CALC;
                    bmag_d  = bmagIn;
                    sign_d  = a_i[W-1] ^ b_i[W-1];
                    bzero_d = (b_i == '0);
                    div_d   = {amagIn, {FRAC{1'b0}}};
                    rem_d   = '0;
                    quo_d   = '0;
                    cnt_d   = '0;
                end
            end

            CALC: begin
                div_d = {div_q[ITER-2:0], 1'b0};
                if (remShift >= {1'b0, bmag_q}) begin
                    rem_d = remShift - {1'b0, bmag_q};
                    quo_d = {quo_q[ITER-2:0], 1'b1};
                end else begin
                    rem_d = remShift;
                    quo_d = {quo_q[ITER-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ITER - 1)) begin
                    state_d = FIN;
                end
            end

            FIN: begin
                // Negative results reach one step further than positive ones.
                if (sign_q) begin
                    if (quo_q > NEG_LIM) begin
                        mag   = NEG_MAX;
                        clamp = 1'b1;
                    end else begin
                        mag = quo_q[W:0];
                    end
                    q_d = ~mag + (W+1)'(1);
                end else begin
                    if (quo_q > POS_LIM) begin
                        mag   = POS_MAX;
                        clamp = 1'b1;
                    end else begin
                        mag = quo_q[W:0];
                    end
                    q_d = mag;
                end
                sat_d = clamp;
                dz_d  = 1'b0;

                // With b == 0 the sign is just the dividend's sign.
                if (bzero_q) begin
                    q_d   = sign_q ? NEG_MAX : POS_MAX;
                    dz_d  = 1'b1;
                    sat_d = 1'b1;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bmag_q  <= '0;
            sign_q  <= 1'b0;
            bzero_q <= 1'b0;
            div_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            dz_q    <= 1'b0;
            sat_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bmag_q  <= bmag_d;
            sign_q  <= sign_d;
            bzero_q <= bzero_d;
            div_q   <= div_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            dz_q    <= dz_d;
            sat_q   <= sat_d;
            done_q  <= done_d;
        end
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = done_q;
    assign q_o    = q_q;
    assign dz_o   = dz_q;
    assign sat_o  = sat_q;

endmodule

// File: tb/tb_fixedpoint_div.sv
// Bench for fixedpoint_div: directed vector table, handshake/reset sequences,
// and random operands checked against an arithmetic reference model.
module tb_fixedpoint_div;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [15:0] a_i;
    logic [15:0] b_i;
    logic        busy_o;
    logic        done_o;
    logic [16:0] q_o;
    logic        dz_o;
    logic        sat_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [16:0] q;
        logic        dz;
        logic        sat;
    } vec_t;

    vec_t vecs[11];

    fixedpoint_div #(.W(16), .FRAC(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start_i(start_i),
        .a_i    (a_i),
        .b_i    (b_i),
        .busy_o (busy_o),
        .done_o (done_o),
        .q_o    (q_o),
        .dz_o   (dz_o),
        .sat_o  (sat_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: real division of magnitudes scaled by 2^FRAC, then clamp.
    function automatic void refModel(input logic [15:0] a, input logic [15:0] b,
                                     output logic [16:0] q, output logic dz, output logic sat);
        longint av = longint'($signed(a));
        longint bv = longint'($signed(b));
        longint mag;
        bit     neg;
        dz  = 1'b0;
        sat = 1'b0;
        if (bv == 0) begin
            dz  = 1'b1;
            sat = 1'b1;
            q   = (av >= 0) ? 17'h0FFFF : 17'h10000;
            return;
        end
        neg = (av < 0) != (bv < 0);
        mag = ((av < 0 ? -av : av) * 256) / (bv < 0 ? -bv : bv);
        if (!neg && mag > 65535) begin
            mag = 65535;
            sat = 1'b1;
        end
        if (neg && mag > 65536) begin
            mag = 65536;
            sat = 1'b1;
        end
        q = neg ? 17'(-mag) : 17'(mag);
    endfunction

    // One full operation: start pulse, bounded wait for done, handshake checks.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                 output logic [16:0] q, output logic dz, output logic sat,
                                 output int lat);
        bit gap     = 1'b0;
        bit overlap = 1'b0;
        lat = -1;
        @(negedge clk);
        a_i     = a;
        b_i     = b;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        a_i     = 16'($urandom);
        b_i     = 16'($urandom);
        if (!busy_o) gap = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (busy_o && done_o) overlap = 1'b1;
            if (done_o) begin
                lat = n;
                break;
            end
            if (!busy_o) gap = 1'b1;
        end
        if (lat < 0) begin
            checkOutput("done_timeout", 32'(0), 32'(1));
        end
        q   = q_o;
        dz  = dz_o;
        sat = sat_o;
        checkOutput("busy_gap", 32'(gap), 32'(0));
        checkOutput("busy_done_overlap", 32'(overlap), 32'(0));
        @(posedge clk);
        #1;
        checkOutput("done_one_cycle", 32'(done_o), 32'(0));
    endtask

    initial begin
        logic [16:0] q, rq;
        logic        dz, sat, rdz, rsat;
        int          lat;
        int          first, second;
        logic [16:0] q1, q2;
        logic [15:0] ra, rb;

        vecs[0]  = '{16'h0200, 16'h0100, 17'h00200, 1'b0, 1'b0};
        vecs[1]  = '{16'hA440, 16'h2120, 17'h1FD3B, 1'b0, 1'b0};
        vecs[2]  = '{16'h0100, 16'hFF00, 17'h1FF00, 1'b0, 1'b0};
        vecs[3]  = '{16'h7FFF, 16'h0001, 17'h0FFFF, 1'b0, 1'b1};
        vecs[4]  = '{16'h8000, 16'h0001, 17'h10000, 1'b0, 1'b1};
        vecs[5]  = '{16'h8000, 16'hFFFF, 17'h0FFFF, 1'b0, 1'b1};
        vecs[6]  = '{16'h0100, 16'h0000, 17'h0FFFF, 1'b1, 1'b1};
        vecs[7]  = '{16'hFF00, 16'h0000, 17'h10000, 1'b1, 1'b1};
        vecs[8]  = '{16'h0300, 16'h0100, 17'h00300, 1'b0, 1'b0};
        vecs[9]  = '{16'h8000, 16'h0080, 17'h10000, 1'b0, 1'b0};
        vecs[10] = '{16'hFFFF, 16'h7FFF, 17'h00000, 1'b0, 1'b0};

        rst_n   = 1'b0;
        start_i = 1'b0;
        a_i     = '0;
        b_i     = '0;
        repeat (10) @(negedge clk);
        checkOutput("reset_busy", 32'(busy_o), 32'(0));
        checkOutput("reset_done", 32'(done_o), 32'(0));
        checkOutput("reset_q", 32'(q_o), 32'(0));
        checkOutput("reset_dz", 32'(dz_o), 32'(0));
        checkOutput("reset_sat", 32'(sat_o), 32'(0));
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, q, dz, sat, lat);
            checkOutput($sformatf("vec%0d_q", i), 32'(q), 32'(vecs[i].q));
            checkOutput($sformatf("vec%0d_dz", i), 32'(dz), 32'(vecs[i].dz));
            checkOutput($sformatf("vec%0d_sat", i), 32'(sat), 32'(vecs[i].sat));
            checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(25));
        end

        // Start pulses during CALC and during the FIN cycle must be ignored.
        @(negedge clk);
        a_i     = 16'h0200;
        b_i     = 16'h0100;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            start_i = (n == 3 || n == 15 || n == 24);
            a_i     = 16'h7FFF;
            b_i     = 16'h0001;
            if (done_o) begin
                lat = n;
                break;
            end
        end
        start_i = 1'b0;
        checkOutput("ignore_start_q", 32'(q_o), 32'h00200);
        checkOutput("ignore_start_sat", 32'(sat_o), 32'(0));
        checkOutput("ignore_start_latency", 32'(lat), 32'(25));
        repeat (2) @(posedge clk);
        #1;
        checkOutput("ignore_start_idle", 32'(busy_o), 32'(0));

        // Start held through done launches the next op straight away.
        @(negedge clk);
        a_i     = 16'h0200;
        b_i     = 16'h0100;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        first  = -1;
        second = -1;
        q1     = '0;
        q2     = '0;
        for (int n = 1; n <= 80; n++) begin
            @(posedge clk);
            #1;
            if (done_o) begin
                if (first < 0) begin
                    first = n;
                    q1    = q_o;
                    a_i   = 16'h0300;
                end else begin
                    second  = n;
                    q2      = q_o;
                    start_i = 1'b0;
                    break;
                end
            end
        end
        start_i = 1'b0;
        checkOutput("b2b_first_latency", 32'(first), 32'(25));
        checkOutput("b2b_first_q", 32'(q1), 32'h00200);
        checkOutput("b2b_gap", 32'(second - first), 32'(26));
        checkOutput("b2b_second_q", 32'(q2), 32'h00300);
        repeat (2) @(posedge clk);

        // Leave dz/sat set so the mid-op reset has something to clear.
        applyStimulus(16'h0100, 16'h0000, q, dz, sat, lat);
        checkOutput("pre_reset_dz", 32'(dz), 32'(1));

        @(negedge clk);
        a_i     = 16'h0200;
        b_i     = 16'h0100;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_busy", 32'(busy_o), 32'(0));
        checkOutput("midreset_done", 32'(done_o), 32'(0));
        checkOutput("midreset_q", 32'(q_o), 32'(0));
        checkOutput("midreset_dz", 32'(dz_o), 32'(0));
        checkOutput("midreset_sat", 32'(sat_o), 32'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(16'h0300, 16'h0100, q, dz, sat, lat);
        checkOutput("post_reset_q", 32'(q), 32'h00300);
        checkOutput("post_reset_latency", 32'(lat), 32'(25));

        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = 16'($urandom);
                1:       rb = 16'($urandom_range(1, 255));
                2:       rb = 16'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(256, 4095));
                default: rb = 16'($urandom_range(0, 32767));
            endcase
            if ($urandom_range(0, 1) == 1) rb = 16'(0) - rb;
            refModel(ra, rb, rq, rdz, rsat);
            applyStimulus(ra, rb, q, dz, sat, lat);
            checkOutput($sformatf("rand%0d_q(a=%h,b=%h)", i, ra, rb), 32'(q), 32'(rq));
            checkOutput($sformatf("rand%0d_dz", i), 32'(dz), 32'(rdz));
            checkOutput($sformatf("rand%0d_sat", i), 32'(sat), 32'(rsat));
            checkOutput($sformatf("rand%0d_latency", i), 32'(lat), 32'(25));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
